card_frame_rx: RTL and testbench

- Receive-side parser for the inter-board card link. Pops bytes from the UART RX FIFO and reassembles the frames produced by the transmit-side encoder (START, DEAL, DEALER_FINISHED).
- Validates each frame and publishes the decoded events and the dealt-card list to blackjack_FSM. It replaces the flat byte decoder with framed, checksummed reception.

---
 rtl/uart_frame_pkg.sv | 32 +++
 rtl/byte_timeout.sv | 37 +++
 rtl/card_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_card_frame_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Constants and types shared by the card-link frame encoder and receiver.
// A frame is SOF, TYPE, LEN, LEN payload bytes and an XOR checksum.
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE             = 8'hA5;
  localparam logic [7:0] TYPE_START           = 8'h01;
  localparam logic [7:0] TYPE_DEAL            = 8'h02;
  localparam logic [7:0] TYPE_DEALER_FINISHED = 8'h03;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_ERROR
  } state_t;

  // A payload byte carries one card in its low six bits; the top two bits must be clear.
  function automatic logic payload_ok(input logic [7:0] b);
    card_t c;
    c = b[5:0];
    return (b[7:6] == 2'b00) && (c.rank >= 4'd1) && (c.rank <= 4'd13);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached, holding there until cleared.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 650000,
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  assign expired = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/card_frame_rx.sv
// Receive-side card-link parser: pops bytes from the UART RX FIFO, validates
// framed messages and publishes START / DEAL / DEALER_FINISHED events.
module card_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_CARDS      = 8,
  parameter logic [7:0]  SOF            = SOF_BYTE,
  parameter int          TIMEOUT_CYCLES = 650000,
  localparam int         CW             = $clog2(MAX_CARDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             read_data,
  input  logic                   rx_empty,
  output logic                   rd_uart,
  output logic                   decoded_start,
  output logic                   decoded_deal,
  output logic                   decoded_dealer_finished,
  output logic [6*MAX_CARDS-1:0] cards,
  output logic [CW-1:0]          card_count,
  output logic                   frame_error,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [7:0]             type_q, type_d;
  logic [7:0]             len_q, len_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic [6*MAX_CARDS-1:0] shadow_q, shadow_d;
  logic [6*MAX_CARDS-1:0] shadow_masked;
  logic [6*MAX_CARDS-1:0] cards_q, cards_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   in_frame, pop, expired, len_ok;

  assign in_frame = (state_q == ST_TYPE) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  // Gated by rst so no byte is lost from the FIFO while held in reset.
  assign pop = rst && !rx_empty && ((state_q == ST_IDLE) || in_frame);

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (pop || !in_frame),
    .en      (in_frame && rx_empty),
    .expired (expired)
  );

  // Slots beyond LEN are zeroed so a short DEAL never shows stale cards.
  for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_mask
    assign shadow_masked[gi*6 +: 6] = (8'(gi) < len_q) ? shadow_q[gi*6 +: 6] : 6'd0;
  end

  assign len_ok = (type_q == TYPE_DEAL) ?
                  ((read_data >= 8'd1) && (read_data <= 8'(MAX_CARDS))) :
                  (read_data == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      shadow_q <= '0;
      cards_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      shadow_q <= shadow_d;
      cards_q  <= cards_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    shadow_d = shadow_q;
    cards_d  = cards_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (pop && (read_data == SOF)) state_d = ST_TYPE;
      end
      ST_TYPE: begin
        if (pop) begin
          if ((read_data == TYPE_START) || (read_data == TYPE_DEAL) ||
              (read_data == TYPE_DEALER_FINISHED)) begin
            type_d  = read_data;
            chk_d   = read_data;
            state_d = ST_LEN;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_LEN: begin
        if (pop) begin
          if (len_ok) begin
            len_d   = read_data;
            chk_d   = chk_q ^ read_data;
            idx_d   = '0;
            state_d = (read_data != 8'd0) ? ST_PAYLOAD : ST_CHECK;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_PAYLOAD: begin
        if (pop) begin
          if (payload_ok(read_data)) begin
            shadow_d[int'(idx_q)*6 +: 6] = read_data[5:0];
            chk_d = chk_q ^ read_data;
            idx_d = idx_q + 1'b1;
            if ((8'(idx_q) + 8'd1) == len_q) state_d = ST_CHECK;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (pop) begin
          if (read_data == chk_q) begin
            state_d = ST_COMMIT;
            // Cards load on the CHK edge so they are visible alongside the DEAL pulse.
            if (type_q == TYPE_DEAL) begin
              cards_d = shadow_masked;
              count_d = len_q[CW-1:0];
            end
          end else begin
            state_d = ST_ERROR;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_uart                 = pop;
    decoded_start           = (state_q == ST_COMMIT) && (type_q == TYPE_START);
    decoded_deal            = (state_q == ST_COMMIT) && (type_q == TYPE_DEAL);
    decoded_dealer_finished = (state_q == ST_COMMIT) && (type_q == TYPE_DEALER_FINISHED);
    frame_error             = (state_q == ST_ERROR);
    busy                    = (state_q != ST_IDLE);
    cards                   = cards_q;
    card_count              = count_q;
  end

endmodule

// File: tb/tb_card_frame_rx.sv
// Scoreboard bench for card_frame_rx: a queue-modelled RX FIFO feeds frames and
// every decoded event is checked against the expectation pushed with its stimulus.
module tb_card_frame_rx;

  localparam int MAX_CARDS = 8;
  localparam int CW        = 4;
  localparam int TMO       = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [7:0]             read_data = 8'h00;
  logic                   rx_empty = 1'b1;
  logic                   rd_uart;
  logic                   decoded_start, decoded_deal, decoded_dealer_finished;
  logic [6*MAX_CARDS-1:0] cards;
  logic [CW-1:0]          card_count;
  logic                   frame_error, busy;

  always #5 clk = ~clk;

  card_frame_rx #(
    .MAX_CARDS      (MAX_CARDS),
    .SOF            (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .read_data               (read_data),
    .rx_empty                (rx_empty),
    .rd_uart                 (rd_uart),
    .decoded_start           (decoded_start),
    .decoded_deal            (decoded_deal),
    .decoded_dealer_finished (decoded_dealer_finished),
    .cards                   (cards),
    .card_count              (card_count),
    .frame_error             (frame_error),
    .busy                    (busy)
  );

  localparam logic [3:0] EV_START = 4'b0001;
  localparam logic [3:0] EV_DEAL  = 4'b0010;
  localparam logic [3:0] EV_DF    = 4'b0100;
  localparam logic [3:0] EV_ERR   = 4'b1000;

  typedef struct {
    logic [3:0]  kind;
    logic [47:0] cards;
    logic [3:0]  count;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fifo[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [47:0] model_cards = '0;
  logic [3:0]  model_count = '0;
  int          cyc = 0;
  int          last_pop = -100;
  int          run = 0;
  int          max_run = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model plus event monitor, sampled on the falling edge.
  initial begin : fifo_drv
    logic       pop_now;
    logic [3:0] ev;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      ev = {frame_error, decoded_dealer_finished, decoded_deal, decoded_start};
      if (ev != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_evt", 64'(ev), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("[TB] cyc %0d event=%b card_count=%0d cards=%h", cyc, ev, card_count, cards);
          check("evt_kind", 64'(ev), 64'(e.kind));
          check("cards", 64'(cards), 64'(e.cards));
          check("card_count", 64'(card_count), 64'(e.count));
          if (e.lat) check("latency", 64'(cyc - last_pop), 64'd1);
        end
      end
      if (rx_empty) check("rd_when_empty", 64'(rd_uart), 64'd0);
      pop_now = rd_uart;
      if (pop_now) begin
        last_pop = cyc;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(posedge clk);
      #1;
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      rx_empty  = (fifo.size() == 0);
      read_data = rx_empty ? 8'h00 : fifo[0];
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_evt(input logic [3:0] kind, input bit lat);
    exp_t e;
    e.kind  = kind;
    e.cards = model_cards;
    e.count = model_count;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  task automatic send_deal(input int n, input logic [7:0] pl[MAX_CARDS]);
    logic [7:0] chk;
    chk = 8'h02 ^ 8'(n);
    push(8'hA5); push(8'h02); push(8'(n));
    model_cards = '0;
    for (int i = 0; i < n; i++) begin
      push(pl[i]);
      chk = chk ^ pl[i];
      model_cards[i*6 +: 6] = pl[i][5:0];
    end
    push(chk);
    model_count = 4'(n);
    expect_evt(EV_DEAL, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (fifo.size() == 0 && !busy && !rd_uart) break;
    end
    check({tag, "_done"}, 64'(k < 300), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    logic [7:0] pl[MAX_CARDS];

    repeat (3) @(negedge clk);
    check("rst_cards", 64'(cards), 64'd0);
    check("rst_count", 64'(card_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd", 64'(rd_uart), 64'd0);
    check("rst_pulses", 64'({frame_error, decoded_dealer_finished, decoded_deal, decoded_start}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    push(8'hA5); push(8'h01); push(8'h00); push(8'h01);
    expect_evt(EV_START, 1'b1);
    wait_done("start");

    max_run = 0;
    pl = '{default: 8'h00};
    pl[0] = 8'h0A; pl[1] = 8'h1C; pl[2] = 8'h25;
    send_deal(3, pl);
    wait_done("deal3");
    check("deal3_b2b_pops", 64'(max_run), 64'd7);
    check("deal3_low", 64'(cards[17:0]), 64'h25_70A & 64'h3FFFF | 64'((6'h25 << 12) | (6'h1C << 6) | 6'h0A));

    push(8'hA5); push(8'h02); push(8'h02); push(8'h0A); push(8'h1C); push(8'h00);
    expect_evt(EV_ERR, 1'b1);
    wait_done("bad_chk");

    push(8'h00); push(8'hFF); push(8'hA5); push(8'h03); push(8'h00); push(8'h03);
    expect_evt(EV_DF, 1'b1);
    wait_done("garbage_df");

    push(8'hA5); push(8'h02); push(8'h09);
    expect_evt(EV_ERR, 1'b1);
    push(8'hA5); push(8'h01); push(8'h00); push(8'h01);
    expect_evt(EV_START, 1'b1);
    wait_done("len_big");

    push(8'hA5); push(8'h02); push(8'h01); push(8'h0E);
    expect_evt(EV_ERR, 1'b1);
    for (int i = 0; i < MAX_CARDS; i++)
      pl[i] = {2'b00, 2'(i), 4'(i + 6)};
    send_deal(MAX_CARDS, pl);
    wait_done("rank14_then_full");

    push(8'hA5); push(8'h02); push(8'h00);
    expect_evt(EV_ERR, 1'b1);
    push(8'hA5); push(8'h02); push(8'h01); push(8'hA5);
    expect_evt(EV_ERR, 1'b1);
    push(8'hA5); push(8'h07);
    expect_evt(EV_ERR, 1'b1);
    wait_done("misc_err");

    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(1, MAX_CARDS));
      pl = '{default: 8'h00};
      for (int i = 0; i < n; i++)
        pl[i] = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 13))};
      send_deal(n, pl);
      wait_done("rand_deal");
    end

    push(8'hA5); push(8'h02);
    expect_evt(EV_ERR, 1'b0);
    wait_done("timeout");
    check("timeout_busy", 64'(busy), 64'd0);

    push(8'hA5); push(8'h02); push(8'h03); push(8'h0A);
    repeat (6) @(negedge clk);
    check("midpay_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    model_cards = '0;
    model_count = '0;
    check("midrst_cards", 64'(cards), 64'd0);
    check("midrst_count", 64'(card_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(frame_error), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    push(8'hA5); push(8'h01); push(8'h00); push(8'h01);
    expect_evt(EV_START, 1'b1);
    wait_done("post_rst_start");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
